branch_commit_fifo: RTL and testbench

- Per-branch result queue between one instruction branch's ALU/writeback output and commit_master.
- One instance per branch. Buffers completed results tagged {result, dest, dest_acc, commit_id} in arrival order.
- Presents the head entry to commit_master as that branch's in_valid/result/dest/dest_acc/commit_id.
- Pops the head on commit_master's registered one-cycle in_ready pulse, so a branch can finish out of commit order without stalling until commit_master reaches its id.

---
 rtl/branch_commit_fifo.sv | 90 +++++++++
 tb/tb_branch_commit_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_commit_fifo.sv
// Per-branch in-order result queue feeding commit_master.
// Head entry is presented combinationally; commit_master's in_ready pulse pops it.
module branch_commit_fifo #(
  parameter int unsigned data_width = 16,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [2*data_width-1:0]   wr_result,
  input  logic [3:0]                wr_dest,
  input  logic                      wr_dest_acc,
  input  logic [8:0]                wr_commit_id,
  output logic                      out_valid,
  output logic [2*data_width-1:0]   out_result,
  output logic [3:0]                out_dest,
  output logic                      out_dest_acc,
  output logic [8:0]                out_commit_id,
  input  logic                      out_pop,
  output logic [addr_width:0]       count,
  output logic                      underflow
);

  localparam int unsigned result_width = 2 * data_width;
  localparam int unsigned count_width  = addr_width + 1;

  typedef struct packed {
    logic [result_width-1:0] result;
    logic [3:0]              dest;
    logic                    dest_acc;
    logic [8:0]              commit_id;
  } entry_t;

  entry_t                  mem [depth];
  entry_t                  head;
  logic [addr_width-1:0]   rd_ptr;
  logic [addr_width-1:0]   wr_ptr;
  logic                    push;
  logic                    pop;
  logic                    pop_empty;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign wr_ready  = (count < count_width'(depth));
  assign out_valid = (count != '0);

  assign push      = enable && wr_valid && wr_ready;
  assign pop       = enable && out_pop && out_valid;
  assign pop_empty = enable && out_pop && !out_valid;

  assign head          = mem[rd_ptr];
  assign out_result    = head.result;
  assign out_dest      = head.dest;
  assign out_dest_acc  = head.dest_acc;
  assign out_commit_id = head.commit_id;

  // Storage is intentionally not cleared by reset; a push coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{result:    wr_result,
                       dest:      wr_dest,
                       dest_acc:  wr_dest_acc,
                       commit_id: wr_commit_id};
    end
  end

  // Pointer, occupancy and sticky underflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + addr_width'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_width'(1);
      end
      count <= count + count_width'(push) - count_width'(pop);
      if (pop_empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_commit_fifo.sv
// Directed bench for branch_commit_fifo with hand-computed expectations.
module tb_branch_commit_fifo;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_result;
  logic [3:0]  wr_dest;
  logic        wr_dest_acc;
  logic [8:0]  wr_commit_id;
  logic        out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_dest;
  logic        out_dest_acc;
  logic [8:0]  out_commit_id;
  logic        out_pop;
  logic [2:0]  count;
  logic        underflow;

  int tests_run;
  int tests_failed;

  branch_commit_fifo #(.data_width(16), .depth(4), .addr_width(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_result     (wr_result),
    .wr_dest       (wr_dest),
    .wr_dest_acc   (wr_dest_acc),
    .wr_commit_id  (wr_commit_id),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_dest      (out_dest),
    .out_dest_acc  (out_dest_acc),
    .out_commit_id (out_commit_id),
    .out_pop       (out_pop),
    .count         (count),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input logic [8:0] id);
    return 32'(id) * 32'h0001_0101;
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] id, input logic pop);
    wr_valid     = v;
    wr_commit_id = id;
    wr_result    = res_of(id);
    wr_dest      = id[3:0];
    wr_dest_acc  = id[0];
    out_pop      = pop;
  endtask

  task automatic check_head(input string tag, input logic [8:0] id);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_id"}, 64'(out_commit_id), 64'(id));
    check({tag, "_result"}, 64'(out_result), 64'(res_of(id)));
    check({tag, "_dest"}, 64'(out_dest), 64'(id[3:0]));
    check({tag, "_acc"}, 64'(out_dest_acc), 64'(id[0]));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    drive(1'b0, 9'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_underflow", 64'(underflow), 64'd0);

    // Single push becomes visible right after its edge.
    wr_valid = 1'b1; wr_result = 32'h0001_2345; wr_dest = 4'd3; wr_dest_acc = 1'b0; wr_commit_id = 9'd0;
    step();
    drive(1'b0, 9'd0, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_dest", 64'(out_dest), 64'd3);
    check("t1_id", 64'(out_commit_id), 64'd0);
    check("t1_result", 64'(out_result), 64'h0001_2345);
    check("t1_count", 64'(count), 64'd1);
    check("t1_wr_ready", 64'(wr_ready), 64'd1);
    drive(1'b0, 9'd0, 1'b1);
    step();
    drive(1'b0, 9'd0, 1'b0);
    check("t1_drain_valid", 64'(out_valid), 64'd0);

    // Fill to depth, drop a fifth push, drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'(i), 1'b0);
      step();
    end
    check("t2_full_count", 64'(count), 64'd4);
    check("t2_full_ready", 64'(wr_ready), 64'd0);
    drive(1'b1, 9'd4, 1'b0);
    step();
    drive(1'b0, 9'd0, 1'b0);
    check("t2_drop_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_head("t2_pop", 9'(i));
      drive(1'b0, 9'd0, 1'b1);
      step();
      drive(1'b0, 9'd0, 1'b0);
    end
    check("t2_empty_valid", 64'(out_valid), 64'd0);
    check("t2_empty_count", 64'(count), 64'd0);
    check("t2_underflow", 64'(underflow), 64'd0);

    // Simultaneous push and pop at count 2.
    drive(1'b1, 9'd5, 1'b0); step();
    drive(1'b1, 9'd6, 1'b0); step();
    drive(1'b1, 9'd7, 1'b1); step();
    drive(1'b0, 9'd0, 1'b0);
    check("t3_count", 64'(count), 64'd2);
    check_head("t3_head6", 9'd6);
    drive(1'b0, 9'd0, 1'b1); step();
    check_head("t3_head7", 9'd7);
    step();
    drive(1'b0, 9'd0, 1'b0);
    check("t3_empty", 64'(out_valid), 64'd0);

    // Full with push and pop: only the pop lands.
    for (int i = 10; i < 14; i++) begin
      drive(1'b1, 9'(i), 1'b0);
      step();
    end
    drive(1'b1, 9'd14, 1'b1); step();
    drive(1'b0, 9'd0, 1'b0);
    check("t4_count", 64'(count), 64'd3);
    check("t4_ready", 64'(wr_ready), 64'd1);
    for (int i = 11; i < 14; i++) begin
      check_head("t4_pop", 9'(i));
      drive(1'b0, 9'd0, 1'b1);
      step();
      drive(1'b0, 9'd0, 1'b0);
    end
    check("t4_empty", 64'(out_valid), 64'd0);
    check("t4_count0", 64'(count), 64'd0);

    // Underflow is sticky until reset.
    drive(1'b0, 9'd0, 1'b1); step();
    drive(1'b0, 9'd0, 1'b0);
    check("t5_underflow", 64'(underflow), 64'd1);
    check("t5_count", 64'(count), 64'd0);
    drive(1'b1, 9'd20, 1'b0); step();
    drive(1'b0, 9'd0, 1'b1); step();
    drive(1'b0, 9'd0, 1'b0);
    check("t5_sticky", 64'(underflow), 64'd1);
    check("t5_count_after", 64'(count), 64'd0);
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_rst_underflow", 64'(underflow), 64'd0);
    check("t5_rst_count", 64'(count), 64'd0);

    // Pointer wrap with steady push/pop pairs.
    drive(1'b1, 9'd30, 1'b0); step();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 9'(30 + k), 1'b1);
      step();
      check("t6_wrap_count", 64'(count), 64'd1);
      check("t6_wrap_id", 64'(out_commit_id), 64'(30 + k));
    end
    check_head("t6_wrap_head", 9'd50);

    // enable low freezes everything even with push and pop asserted.
    enable = 1'b0;
    drive(1'b1, 9'd99, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_frz_count", 64'(count), 64'd1);
      check("t6_frz_id", 64'(out_commit_id), 64'd50);
      check("t6_frz_underflow", 64'(underflow), 64'd0);
    end
    enable = 1'b1;
    drive(1'b1, 9'd60, 1'b0); step();
    check("t6_resume_count", 64'(count), 64'd2);
    check_head("t6_resume_head", 9'd50);

    // Reset mid-stream discards concurrent push/pop.
    reset = 1'b1;
    drive(1'b1, 9'd61, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, 9'd0, 1'b0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_ready", 64'(wr_ready), 64'd1);
    step();
    check("t6_rst_hold", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
